// File: rtl/port_dma_pkg.sv
// Shared definitions for the port-bus DMA engine and the peripherals it talks to.
//   - dma_state_t  : engine state encoding (3 bits)
//   - PORT_*_DEF   : default port IDs, also used by the peripheral address decoders
//   - status_full  : extracts the "FIFO full" flag from a status byte
package port_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SET_ADDR = 3'd1,
        ST_READ_MEM = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_EVAL     = 3'd4,
        ST_POLL     = 3'd5,
        ST_NEXT     = 3'd6
    } dma_state_t;

    localparam logic [7:0] PORT_ADDR_DEF = 8'h01;   // memory address register (write)
    localparam logic [7:0] PORT_MEM_DEF  = 8'h02;   // memory data (read)
    localparam logic [7:0] PORT_FIFO_DEF = 8'h03;   // FIFO data (write)
    localparam logic [7:0] PORT_STAT_DEF = 8'h04;   // FIFO status (read)

    // Returns the full flag located at bit_idx of a FIFO status byte.
    function automatic logic status_full(input logic [7:0] status, input logic [2:0] bit_idx);
        return status[bit_idx];
    endfunction

endpackage

// File: rtl/port_dma_engine_if.sv
// KCPSM6-style port bus: one port address, one write-data byte, one read-data
// byte and single-cycle read/write qualifiers.
//   master : drives port_id, out_port, write_strobe, read_strobe; receives in_port
//   slave  : the peripheral side, returns in_port one cycle after read_strobe
interface port_dma_engine_if;

    logic [7:0] port_id;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic       write_strobe;
    logic       read_strobe;

    modport master (
        output port_id,
        output out_port,
        output write_strobe,
        output read_strobe,
        input  in_port
    );

    modport slave (
        input  port_id,
        input  out_port,
        input  write_strobe,
        input  read_strobe,
        output in_port
    );

endinterface

// File: rtl/port_dma_engine.sv
// Port-bus DMA master: copies a programmable run of bytes from a port-mapped
// memory window into a port-mapped FIFO, using the same port_id/strobe bus a
// PicoBlaze would. Supports one-shot and circular jobs, bounded retry while
// the FIFO reports full (error on exhaustion) and abort.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   start         one-cycle job request, honoured only while idle
//   abort         terminates the current job at the next edge
//   base_addr     first memory address        (latched at start)
//   length        bytes per pass              (latched at start)
//   circular      restart at base after last  (latched at start)
//   busy          job active
//   done          one-cycle pulse at one-shot completion
//   error         sticky retry-exhaustion flag, cleared by the next accepted start
//   count         bytes written to the FIFO in the current pass
//   bus           port bus master (port_id, out_port, in_port, strobes)
//
// Every output is a register. Each state's bus action is computed on the
// transition into that state, so the strobe is high exactly while the engine
// sits in the state that owns it, and in_port (registered by the peripheral)
// is consumed in the following state.
module port_dma_engine
    import port_dma_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned LEN_W     = 8,
    parameter logic [7:0]  PORT_ADDR = PORT_ADDR_DEF,
    parameter logic [7:0]  PORT_MEM  = PORT_MEM_DEF,
    parameter logic [7:0]  PORT_FIFO = PORT_FIFO_DEF,
    parameter logic [7:0]  PORT_STAT = PORT_STAT_DEF,
    parameter int unsigned FULL_BIT  = 0,
    parameter int unsigned RETRY_MAX = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              circular,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [LEN_W-1:0]  count,
    port_dma_engine_if.master bus
);

    // retry only has to count up to RETRY_MAX-1
    localparam int unsigned RETRY_W = (RETRY_MAX > 1) ? $clog2(RETRY_MAX) : 1;

    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_MAX - 1);
    localparam logic [RETRY_W-1:0] RETRY_ONE  = RETRY_W'(1);
    localparam logic [LEN_W-1:0]   LEN_ONE    = LEN_W'(1);
    localparam logic [LEN_W-1:0]   LEN_ZERO   = LEN_W'(0);
    localparam logic [ADDR_W-1:0]  ADDR_ONE   = ADDR_W'(1);
    localparam logic [2:0]         FULL_IDX   = 3'(FULL_BIT);

    // State and job registers
    dma_state_t          state_r,     state_s;
    logic [ADDR_W-1:0]   base_r,      base_s;
    logic [LEN_W-1:0]    len_r,       len_s;
    logic                circ_r,      circ_s;
    logic [ADDR_W-1:0]   ptr_r,       ptr_s;
    logic [LEN_W-1:0]    remaining_r, remaining_s;
    logic [7:0]          data_r,      data_s;
    logic [RETRY_W-1:0]  retry_r,     retry_s;

    // Output registers
    logic                busy_r,      busy_s;
    logic                done_r,      done_s;
    logic                error_r,     error_s;
    logic [LEN_W-1:0]    count_r,     count_s;
    logic [7:0]          port_id_r,   port_id_s;
    logic [7:0]          out_port_r,  out_port_s;
    logic                wr_r,        wr_s;
    logic                rd_r,        rd_s;

    logic [ADDR_W-1:0]   ptr_inc_s;
    logic                fifo_full_s;

    // Pointer increment wraps naturally modulo 2^ADDR_W.
    assign ptr_inc_s   = ptr_r + ADDR_ONE;
    assign fifo_full_s = status_full(bus.in_port, FULL_IDX);

    // State register and all output/datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            base_r      <= '0;
            len_r       <= '0;
            circ_r      <= 1'b0;
            ptr_r       <= '0;
            remaining_r <= '0;
            data_r      <= '0;
            retry_r     <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            count_r     <= '0;
            port_id_r   <= '0;
            out_port_r  <= '0;
            wr_r        <= 1'b0;
            rd_r        <= 1'b0;
        end else begin
            state_r     <= state_s;
            base_r      <= base_s;
            len_r       <= len_s;
            circ_r      <= circ_s;
            ptr_r       <= ptr_s;
            remaining_r <= remaining_s;
            data_r      <= data_s;
            retry_r     <= retry_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            error_r     <= error_s;
            count_r     <= count_s;
            port_id_r   <= port_id_s;
            out_port_r  <= out_port_s;
            wr_r        <= wr_s;
            rd_r        <= rd_s;
        end
    end

    // Next-state logic; bus values are prepared for the state being entered
    always_comb begin
        state_s     = state_r;
        base_s      = base_r;
        len_s       = len_r;
        circ_s      = circ_r;
        ptr_s       = ptr_r;
        remaining_s = remaining_r;
        data_s      = data_r;
        retry_s     = retry_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        error_s     = error_r;
        count_s     = count_r;
        port_id_s   = port_id_r;          // port_id holds between strobes
        out_port_s  = out_port_r;
        wr_s        = 1'b0;
        rd_s        = 1'b0;

        if ((state_r != ST_IDLE) && abort) begin
            // Abort beats every other transition; a strobe already on the bus
            // this cycle still completes, no further strobe is issued.
            state_s = ST_IDLE;
            busy_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && !abort) begin
                        base_s      = base_addr;
                        len_s       = length;
                        circ_s      = circular;
                        ptr_s       = base_addr;
                        remaining_s = length;
                        count_s     = '0;
                        error_s     = 1'b0;
                        if (length != LEN_ZERO) begin
                            state_s    = ST_SET_ADDR;
                            busy_s     = 1'b1;
                            port_id_s  = PORT_ADDR;
                            out_port_s = 8'(base_addr);
                            wr_s       = 1'b1;
                        end else begin
                            // empty job: completes immediately without touching the bus
                            done_s = 1'b1;
                        end
                    end else begin
                        busy_s = 1'b0;
                    end
                end

                ST_SET_ADDR: begin
                    state_s   = ST_READ_MEM;
                    port_id_s = PORT_MEM;
                    rd_s      = 1'b1;
                end

                ST_READ_MEM: begin
                    state_s   = ST_CAPTURE;
                    port_id_s = PORT_STAT;
                    rd_s      = 1'b1;
                end

                ST_CAPTURE: begin
                    // memory responded to READ_MEM's strobe; status read is on the bus now
                    data_s  = bus.in_port;
                    retry_s = '0;
                    state_s = ST_EVAL;
                end

                ST_EVAL: begin
                    if (!fifo_full_s) begin
                        state_s    = ST_NEXT;
                        port_id_s  = PORT_FIFO;
                        out_port_s = data_r;
                        wr_s       = 1'b1;
                        count_s    = count_r + LEN_ONE;
                    end else if (retry_r == RETRY_LAST) begin
                        state_s = ST_IDLE;
                        busy_s  = 1'b0;
                        error_s = 1'b1;
                    end else begin
                        // re-poll status only; the captured memory byte is kept
                        state_s   = ST_POLL;
                        retry_s   = retry_r + RETRY_ONE;
                        port_id_s = PORT_STAT;
                        rd_s      = 1'b1;
                    end
                end

                ST_POLL: begin
                    state_s = ST_EVAL;
                end

                ST_NEXT: begin
                    if (remaining_r == LEN_ONE) begin
                        if (circ_r) begin
                            state_s     = ST_SET_ADDR;
                            ptr_s       = base_r;
                            remaining_s = len_r;
                            count_s     = '0;
                            port_id_s   = PORT_ADDR;
                            out_port_s  = 8'(base_r);
                            wr_s        = 1'b1;
                        end else begin
                            state_s = ST_IDLE;
                            busy_s  = 1'b0;
                            done_s  = 1'b1;
                        end
                    end else begin
                        state_s     = ST_SET_ADDR;
                        ptr_s       = ptr_inc_s;
                        remaining_s = remaining_r - LEN_ONE;
                        port_id_s   = PORT_ADDR;
                        out_port_s  = 8'(ptr_inc_s);
                        wr_s        = 1'b1;
                    end
                end

                default: begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                end
            endcase
        end
    end

    assign busy             = busy_r;
    assign done             = done_r;
    assign error            = error_r;
    assign count            = count_r;
    assign bus.port_id      = port_id_r;
    assign bus.out_port     = out_port_r;
    assign bus.write_strobe = wr_r;
    assign bus.read_strobe  = rd_r;

endmodule

// File: tb/tb_port_dma_engine.sv
// Directed bench for port_dma_engine: a registered memory/FIFO peripheral
// model on the port bus, event logs, and hand-computed expectations.
module tb_port_dma_engine;
    import port_dma_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] base_addr;
    logic [7:0] length;
    logic       circular;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] count;

    port_dma_engine_if bus();

    port_dma_engine #(
        .ADDR_W(8), .LEN_W(8), .RETRY_MAX(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .base_addr(base_addr), .length(length), .circular(circular),
        .busy(busy), .done(done), .error(error), .count(count),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Compare one observed value against its expected value.
    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Memory contents as a function of address.
    function automatic logic [7:0] mem_val(input logic [7:0] a);
        return (a * 8'd3) ^ 8'h5A;
    endfunction

    // Peripheral model and bus monitor state
    int         cyc = 0;
    int         busy_rise_cyc = 0;
    int         done_cyc = 0;
    int         done_cnt = 0;
    int         strobe_cnt = 0;
    int         mem_reads = 0;
    int         stat_reads = 0;
    int         full_budget = 0;
    int         arm_idx = -1;
    int         arm_n = 0;
    bit         stuck = 1'b0;
    logic       busy_q = 1'b0;
    logic [7:0] addr_reg = 8'h00;
    logic [7:0] addr_log[$];
    int         addr_cnt_log[$];
    logic [7:0] fifo_log[$];
    int         fifo_cyc[$];

    // Peripheral: address register, memory, FIFO sink and status register
    always @(posedge clk) begin
        if (busy && !busy_q) busy_rise_cyc = cyc;
        busy_q = busy;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.write_strobe || bus.read_strobe) strobe_cnt++;
        if (bus.write_strobe && bus.port_id == PORT_ADDR_DEF) begin
            addr_reg = bus.out_port;
            addr_log.push_back(bus.out_port);
            addr_cnt_log.push_back(int'(count));
        end
        if (bus.write_strobe && bus.port_id == PORT_FIFO_DEF) begin
            fifo_log.push_back(bus.out_port);
            fifo_cyc.push_back(cyc);
        end
        if (bus.read_strobe && bus.port_id == PORT_MEM_DEF) begin
            bus.in_port <= mem_val(addr_reg);
            if (mem_reads == arm_idx) full_budget = arm_n;
            mem_reads++;
        end else if (bus.read_strobe && bus.port_id == PORT_STAT_DEF) begin
            stat_reads++;
            if (stuck || full_budget > 0) begin
                bus.in_port <= 8'hF1;     // full, other bits set as noise
                if (full_budget > 0) full_budget--;
            end else begin
                bus.in_port <= 8'hF0;
            end
        end else begin
            bus.in_port <= 8'h00;
        end
        cyc++;
    end

    task automatic clear_logs();
        addr_log.delete();
        addr_cnt_log.delete();
        fifo_log.delete();
        fifo_cyc.delete();
        done_cnt    = 0;
        strobe_cnt  = 0;
        mem_reads   = 0;
        stat_reads  = 0;
        full_budget = 0;
        arm_idx     = -1;
        arm_n       = 0;
        stuck       = 1'b0;
    endtask

    // Drive a one-cycle start; returns at the negedge of the first job cycle.
    task automatic pulse_start(input logic [7:0] b, input logic [7:0] l, input logic c, input logic ab);
        @(negedge clk);
        base_addr = b;
        length    = l;
        circular  = c;
        start     = 1'b1;
        abort     = ab;
        @(negedge clk);
        start     = 1'b0;
        abort     = 1'b0;
    endtask

    // Wait (bounded) for busy to drop, then let the done cycle be sampled.
    task automatic wait_idle(input string tag, input int max_cyc);
        int n = 0;
        while (busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic quiet_window(input string tag);
        strobe_cnt = 0;
        repeat (10) @(negedge clk);
        check_val(tag, 32'(strobe_cnt), 32'd0);
    endtask

    initial begin
        logic [7:0] exp_circ [5];
        exp_circ = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'hFE};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        base_addr = 8'h00; length = 8'h00; circular = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        check_val("rst_busy",  32'(busy), 32'd0);
        check_val("rst_done",  32'(done), 32'd0);
        check_val("rst_error", 32'(error), 32'd0);
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_bus",   32'({bus.port_id, bus.out_port, bus.write_strobe, bus.read_strobe}), 32'd0);

        // one-shot, FIFO never full
        clear_logs();
        pulse_start(8'h10, 8'd4, 1'b0, 1'b0);
        check_val("t1_busy_rise", 32'(busy), 32'd1);
        wait_idle("t1_idle", 60);
        check_val("t1_naddr", 32'(addr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_val("t1_addr", 32'(addr_log[i]), 32'h10 + 32'(i));
            check_val("t1_fifo", 32'(fifo_log[i]), 32'(mem_val(8'(8'h10 + i))));
        end
        check_val("t1_nfifo", 32'(fifo_log.size()), 32'd4);
        check_val("t1_done_cnt", 32'(done_cnt), 32'd1);
        check_val("t1_done_lat", 32'(done_cyc - busy_rise_cyc), 32'd20);
        check_val("t1_count", 32'(count), 32'd4);
        check_val("t1_gap", 32'(fifo_cyc[1] - fifo_cyc[0]), 32'd5);

        // three full polls on byte index 2
        clear_logs();
        arm_idx = 2;
        arm_n   = 3;
        pulse_start(8'h20, 8'd4, 1'b0, 1'b0);
        wait_idle("t2_idle", 80);
        check_val("t2_nfifo", 32'(fifo_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check_val("t2_fifo", 32'(fifo_log[i]), 32'(mem_val(8'(8'h20 + i))));
        check_val("t2_mem_reads", 32'(mem_reads), 32'd4);
        check_val("t2_stat_reads", 32'(stat_reads), 32'd7);
        check_val("t2_gap", 32'(fifo_cyc[2] - fifo_cyc[1]), 32'd11);
        check_val("t2_done_lat", 32'(done_cyc - busy_rise_cyc), 32'd26);
        check_val("t2_error", 32'(error), 32'd0);

        // FIFO stuck full: retry exhaustion
        clear_logs();
        stuck = 1'b1;
        pulse_start(8'h30, 8'd2, 1'b0, 1'b0);
        wait_idle("t3_idle", 60);
        check_val("t3_error", 32'(error), 32'd1);
        check_val("t3_busy", 32'(busy), 32'd0);
        check_val("t3_done_cnt", 32'(done_cnt), 32'd0);
        check_val("t3_stat_reads", 32'(stat_reads), 32'd4);
        check_val("t3_nfifo", 32'(fifo_log.size()), 32'd0);
        check_val("t3_naddr", 32'(addr_log.size()), 32'd1);

        // circular with pointer wrap, then abort
        clear_logs();
        pulse_start(8'hFE, 8'd4, 1'b1, 1'b0);
        check_val("t4_error_clr", 32'(error), 32'd0);
        repeat (30) @(negedge clk);
        check_val("t4_naddr", 32'(addr_log.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++)
            check_val("t4_addr", 32'(addr_log[i]), 32'(exp_circ[i]));
        check_val("t4_cnt_pass1_last", 32'(addr_cnt_log[3]), 32'd3);
        check_val("t4_cnt_restart", 32'(addr_cnt_log[4]), 32'd0);
        check_val("t4_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("t4_abort_busy", 32'(busy), 32'd0);
        quiet_window("t4_quiet");
        check_val("t4_done_cnt", 32'(done_cnt), 32'd0);

        // abort while in POLL
        clear_logs();
        stuck = 1'b1;
        pulse_start(8'h40, 8'd3, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check_val("t5_in_poll", 32'({bus.read_strobe, bus.port_id}), 32'h104);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("t5_abort_busy", 32'(busy), 32'd0);
        check_val("t5_abort_strobes", 32'({bus.write_strobe, bus.read_strobe}), 32'd0);
        quiet_window("t5_quiet");
        check_val("t5_done_cnt", 32'(done_cnt), 32'd0);
        check_val("t5_error", 32'(error), 32'd0);

        // abort in the same cycle as start
        clear_logs();
        pulse_start(8'h50, 8'd2, 1'b0, 1'b1);
        check_val("t6_busy", 32'(busy), 32'd0);
        quiet_window("t6_quiet");
        check_val("t6_done_cnt", 32'(done_cnt), 32'd0);

        // zero-length job
        clear_logs();
        pulse_start(8'h60, 8'd0, 1'b0, 1'b0);
        check_val("t7_done", 32'(done), 32'd1);
        check_val("t7_busy", 32'(busy), 32'd0);
        quiet_window("t7_quiet");
        check_val("t7_done_cnt", 32'(done_cnt), 32'd1);

        // reset mid-job, then a normal job
        clear_logs();
        pulse_start(8'h70, 8'd4, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        check_val("t8_pre_count", 32'(count), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("t8_rst_outs", 32'({busy, done, error, count, bus.write_strobe, bus.read_strobe}), 32'd0);
        check_val("t8_rst_bus", 32'({bus.port_id, bus.out_port}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
        pulse_start(8'h10, 8'd2, 1'b0, 1'b0);
        wait_idle("t8_idle", 40);
        check_val("t8_nfifo", 32'(fifo_log.size()), 32'd2);
        check_val("t8_fifo0", 32'(fifo_log[0]), 32'(mem_val(8'h10)));
        check_val("t8_fifo1", 32'(fifo_log[1]), 32'(mem_val(8'h11)));
        check_val("t8_done_cnt", 32'(done_cnt), 32'd1);
        check_val("t8_count", 32'(count), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
